datapath_core: RTL and testbench
================================

DATAPATH_CORE -- requirements
Module: datapath_core

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 8, width of the bus, registers and SP.
- ADDR_WIDTH, 16, width of the PC and MAR; SHALL equal 2*DATA_WIDTH, with an elaboration error otherwise.
- NUM_REGS, 4, number of general registers, in the range 2..16.
- RESET_VECTOR, 16'hF000, PC value after reset.
- SP_INIT, 8'hFF, SP value after reset.
- STACK_PAGE, 8'h01, upper address byte used for stack accesses.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low.
- bus_src  in  3  bus source: 0 zero, 1 mem_data_in, 2 alu_result, 3 reg[src_idx], 4 PC low byte, 5 PC high byte, 6 SP, 7 illegal.
- src_idx  in  4  register read index.
- dst_idx  in  4  register write index.
- reg_we  in  1  write bus into reg[dst_idx].
- mem_data_in  in  DATA_WIDTH  memory read data.
- alu_result  in  DATA_WIDTH  ALU result.
- alu_z / alu_c / alu_n  in  1 each  ALU flags.
- flag_mode  in  2  flag update: 0 hold, 1 ALU, 2 load-ZN, 3 hold.
- pc_inc  in  1  increment PC.
- pc_load_lo  in  1  load PC low byte from bus.
- pc_load_hi  in  1  load PC high byte from bus.
- pc_load_vec  in  1  load RESET_VECTOR into PC.
- mar_src  in  3  MAR source: 0 hold, 1 PC, 2 high byte from bus, 3 low byte from bus, 4 stack, 5-7 hold.
- sp_inc  in  1  increment SP.
- sp_dec  in  1  decrement SP.
- err_clr  in  1  clear sticky errors.
- bus_out  out  DATA_WIDTH  current bus value (combinational).
- reg0_out  out  DATA_WIDTH  reg[0], used as memory write data.
- mem_address  out  ADDR_WIDTH  MAR contents.
- pc_out  out  ADDR_WIDTH  PC.
- sp_out  out  DATA_WIDTH  SP.
- flags_out  out  3  {N,C,Z}.
- bus_err  out  1  sticky bus error.
- sp_wrap  out  1  sticky stack wrap.

Function
REQ-004 The bus SHALL be a combinational index mux driven only from registered state and inputs; bus_src 7 or src_idx>=NUM_REGS SHALL drive zero.
REQ-005 When reg_we=1 and dst_idx<NUM_REGS, reg[dst_idx] SHALL take the bus value at the clock edge; a same-cycle read of that register SHALL return the old value.
REQ-006 flag_mode 1 SHALL latch {alu_n,alu_c,alu_z}; flag_mode 2 SHALL latch Z=(bus==0), N=bus[MSB], C=0; modes 0 and 3 SHALL hold the flags.
REQ-007 PC priority SHALL be pc_load_vec > byte loads > pc_inc.
REQ-008 pc_load_lo and pc_load_hi SHALL write their own byte and may be asserted together; pc_inc SHALL be ignored whenever any load is active.
REQ-009 pc_inc SHALL wrap from all-ones to 0 without flagging.
REQ-010 mar_src 4 SHALL load MAR with {STACK_PAGE, SP}, using SP before any same-cycle SP update.
REQ-011 mar_src 2 and 3 SHALL update only their own MAR byte.
REQ-012 sp_dec SHALL subtract 1 and sp_inc SHALL add 1; both asserted together SHALL hold SP.
REQ-013 A decrement from 0 to all-ones, or an increment from all-ones to 0, SHALL set sp_wrap.
REQ-014 bus_err SHALL set on any cycle with bus_src=7, with src_idx>=NUM_REGS while bus_src=3, or with reg_we=1 and dst_idx>=NUM_REGS.
REQ-015 err_clr SHALL clear bus_err and sp_wrap; if a set event occurs in the same cycle, the set SHALL win.
REQ-016 All state SHALL update only on the rising clock edge, with zero latency from control input to the register at that edge.

Reset
REQ-017 On reset low, the block SHALL set regs=0, PC=RESET_VECTOR, MAR=0, SP=SP_INIT, flags=0, bus_err=0 and sp_wrap=0 immediately, independent of clk.
REQ-018 After reset is released, the first clock edge SHALL act normally.
REQ-019 A reset asserted mid-sequence SHALL abort any pending update with no partial writes.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset low mid-run with PC=0x1234 -> PC=0xF000, SP=0xFF, flags=0 before the next edge.
- bus_src=1, mem_data_in=0x80, reg_we=1, dst_idx=2, flag_mode=2 -> reg[2]=0x80, flags N=1 C=0 Z=1'b0; next cycle bus_src=3, src_idx=2 -> bus_out=0x80.
- PC=0x12FF, pc_inc=1 -> 0x1300; pc_load_hi=1 with bus=0xAB and pc_inc=1 -> 0xAB00, increment suppressed.
- SP=0x00, mar_src=4, sp_dec=1 -> MAR=0x0100, SP=0xFF, sp_wrap=1; err_clr=1 -> sp_wrap=0.
- bus_src=7 -> bus_out=0x00, bus_err=1; err_clr=1 in the same cycle as bus_src=7 -> bus_err stays 1.
- NUM_REGS=3 build, dst_idx=3, reg_we=1 -> no register changes, bus_err=1.

Source files
------------

// File: rtl/datapath_core.sv
// Register file, PC, MAR, SP and flags around one combinational bus; zero-latency register updates.
// Sticky bus_err / sp_wrap flags report illegal bus selects, bad register indices and stack wrap.
module datapath_core #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    NUM_REGS     = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hF000,
  parameter logic [DATA_WIDTH-1:0] SP_INIT      = 8'hFF,
  parameter logic [DATA_WIDTH-1:0] STACK_PAGE   = 8'h01
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            bus_src,
  input  logic [3:0]            src_idx,
  input  logic [3:0]            dst_idx,
  input  logic                  reg_we,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_z,
  input  logic                  alu_c,
  input  logic                  alu_n,
  input  logic [1:0]            flag_mode,
  input  logic                  pc_inc,
  input  logic                  pc_load_lo,
  input  logic                  pc_load_hi,
  input  logic                  pc_load_vec,
  input  logic [2:0]            mar_src,
  input  logic                  sp_inc,
  input  logic                  sp_dec,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic [DATA_WIDTH-1:0] reg0_out,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] sp_out,
  output logic [2:0]            flags_out,
  output logic                  bus_err,
  output logic                  sp_wrap
);

  if (ADDR_WIDTH != 2 * DATA_WIDTH) begin : g_bad_addr_width
    $error("datapath_core: ADDR_WIDTH must equal 2*DATA_WIDTH");
  end
  if (NUM_REGS < 2 || NUM_REGS > 16) begin : g_bad_num_regs
    $error("datapath_core: NUM_REGS must be in 2..16");
  end

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = 1;
  localparam logic [DATA_WIDTH-1:0] SP_ONE = 1;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_mar;
  logic [DATA_WIDTH-1:0] r_sp;
  logic [2:0]            r_flags;
  logic                  r_bus_err;
  logic                  r_sp_wrap;

  logic [DATA_WIDTH-1:0] w_bus;
  logic [DATA_WIDTH-1:0] w_reg_rd;
  logic                  w_src_ok;
  logic                  w_dst_ok;
  logic                  w_err_set;
  logic                  w_sp_up;
  logic                  w_sp_dn;
  logic                  w_wrap_set;

  assign w_src_ok = int'(src_idx) < NUM_REGS;
  assign w_dst_ok = int'(dst_idx) < NUM_REGS;

  always_comb begin
    w_reg_rd = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (src_idx == 4'(i)) w_reg_rd = r_regs[i];
    end
  end

  always_comb begin
    w_bus = '0;
    case (bus_src)
      3'd1:    w_bus = mem_data_in;
      3'd2:    w_bus = alu_result;
      3'd3:    w_bus = w_src_ok ? w_reg_rd : '0;
      3'd4:    w_bus = r_pc[DATA_WIDTH-1:0];
      3'd5:    w_bus = r_pc[ADDR_WIDTH-1:DATA_WIDTH];
      3'd6:    w_bus = r_sp;
      default: w_bus = '0;
    endcase
  end

  assign w_err_set  = (bus_src == 3'd7) || (bus_src == 3'd3 && !w_src_ok) || (reg_we && !w_dst_ok);
  // Simultaneous inc and dec cancel, so neither can flag a wrap.
  assign w_sp_up    = sp_inc && !sp_dec;
  assign w_sp_dn    = sp_dec && !sp_inc;
  assign w_wrap_set = (w_sp_dn && r_sp == '0) || (w_sp_up && r_sp == '1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_we && dst_idx == 4'(i)) r_regs[i] <= w_bus;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_VECTOR;
    end else if (pc_load_vec) begin
      r_pc <= RESET_VECTOR;
    end else if (pc_load_lo || pc_load_hi) begin
      if (pc_load_lo) r_pc[DATA_WIDTH-1:0]          <= w_bus;
      if (pc_load_hi) r_pc[ADDR_WIDTH-1:DATA_WIDTH] <= w_bus;
    end else if (pc_inc) begin
      r_pc <= r_pc + PC_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mar <= '0;
    end else begin
      case (mar_src)
        3'd1:    r_mar <= r_pc;
        3'd2:    r_mar[ADDR_WIDTH-1:DATA_WIDTH] <= w_bus;
        3'd3:    r_mar[DATA_WIDTH-1:0] <= w_bus;
        3'd4:    r_mar <= {STACK_PAGE, r_sp};
        default: r_mar <= r_mar;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sp      <= SP_INIT;
      r_sp_wrap <= 1'b0;
      r_bus_err <= 1'b0;
      r_flags   <= 3'b000;
    end else begin
      if (w_sp_up)      r_sp <= r_sp + SP_ONE;
      else if (w_sp_dn) r_sp <= r_sp - SP_ONE;
      r_sp_wrap <= w_wrap_set || (r_sp_wrap && !err_clr);
      r_bus_err <= w_err_set  || (r_bus_err && !err_clr);
      case (flag_mode)
        2'd1:    r_flags <= {alu_n, alu_c, alu_z};
        2'd2:    r_flags <= {w_bus[DATA_WIDTH-1], 1'b0, (w_bus == '0)};
        default: r_flags <= r_flags;
      endcase
    end
  end

  assign bus_out     = w_bus;
  assign reg0_out    = r_regs[0];
  assign mem_address = r_mar;
  assign pc_out      = r_pc;
  assign sp_out      = r_sp;
  assign flags_out   = r_flags;
  assign bus_err     = r_bus_err;
  assign sp_wrap     = r_sp_wrap;

endmodule

// File: tb/tb_datapath_core.sv
// Randomised plus directed scoreboard bench for datapath_core (NUM_REGS=4 main instance, NUM_REGS=3 side instance).
module tb_datapath_core;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] bus_src;
  logic [3:0] src_idx, dst_idx;
  logic       reg_we;
  logic [7:0] mem_data_in, alu_result;
  logic       alu_z, alu_c, alu_n;
  logic [1:0] flag_mode;
  logic       pc_inc, pc_load_lo, pc_load_hi, pc_load_vec;
  logic [2:0] mar_src;
  logic       sp_inc, sp_dec, err_clr;

  logic [7:0]  bus_out, reg0_out, sp_out;
  logic [15:0] mem_address, pc_out;
  logic [2:0]  flags_out;
  logic        bus_err, sp_wrap;

  logic [7:0]  bus_out_3, reg0_out_3, sp_out_3;
  logic [15:0] mem_address_3, pc_out_3;
  logic [2:0]  flags_out_3;
  logic        bus_err_3, sp_wrap_3;

  int n_tests = 0;
  int n_fail  = 0;

  datapath_core u_dut (
    .clk(clk), .reset(reset), .bus_src(bus_src), .src_idx(src_idx), .dst_idx(dst_idx),
    .reg_we(reg_we), .mem_data_in(mem_data_in), .alu_result(alu_result),
    .alu_z(alu_z), .alu_c(alu_c), .alu_n(alu_n), .flag_mode(flag_mode),
    .pc_inc(pc_inc), .pc_load_lo(pc_load_lo), .pc_load_hi(pc_load_hi), .pc_load_vec(pc_load_vec),
    .mar_src(mar_src), .sp_inc(sp_inc), .sp_dec(sp_dec), .err_clr(err_clr),
    .bus_out(bus_out), .reg0_out(reg0_out), .mem_address(mem_address), .pc_out(pc_out),
    .sp_out(sp_out), .flags_out(flags_out), .bus_err(bus_err), .sp_wrap(sp_wrap)
  );

  datapath_core #(.NUM_REGS(3)) u_dut3 (
    .clk(clk), .reset(reset), .bus_src(bus_src), .src_idx(src_idx), .dst_idx(dst_idx),
    .reg_we(reg_we), .mem_data_in(mem_data_in), .alu_result(alu_result),
    .alu_z(alu_z), .alu_c(alu_c), .alu_n(alu_n), .flag_mode(flag_mode),
    .pc_inc(pc_inc), .pc_load_lo(pc_load_lo), .pc_load_hi(pc_load_hi), .pc_load_vec(pc_load_vec),
    .mar_src(mar_src), .sp_inc(sp_inc), .sp_dec(sp_dec), .err_clr(err_clr),
    .bus_out(bus_out_3), .reg0_out(reg0_out_3), .mem_address(mem_address_3), .pc_out(pc_out_3),
    .sp_out(sp_out_3), .flags_out(flags_out_3), .bus_err(bus_err_3), .sp_wrap(sp_wrap_3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  bus;
    logic [15:0] pc;
    logic [15:0] mar;
    logic [7:0]  sp;
    logic [2:0]  flags;
    logic        err;
    logic        wrap;
    logic [7:0]  reg0;
  } exp_t;

  exp_t q[$];

  // Reference state of the machine (NUM_REGS = 4)
  logic [7:0]  m_regs [16];
  logic [15:0] m_pc, m_mar;
  logic [7:0]  m_sp;
  logic [2:0]  m_flags;
  logic        m_err, m_wrap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_pc = 16'hF000; m_mar = 16'h0000; m_sp = 8'hFF;
    m_flags = 3'b000; m_err = 1'b0; m_wrap = 1'b0;
  endtask

  // Apply the current inputs to the reference and queue the expected result.
  task automatic model_step();
    exp_t e;
    logic [7:0] b;
    logic eset, wset;
    case (bus_src)
      3'd0: b = 8'h00;
      3'd1: b = mem_data_in;
      3'd2: b = alu_result;
      3'd3: b = (src_idx < 4) ? m_regs[src_idx] : 8'h00;
      3'd4: b = m_pc[7:0];
      3'd5: b = m_pc[15:8];
      3'd6: b = m_sp;
      default: b = 8'h00;
    endcase
    eset = (bus_src == 7) || (bus_src == 3 && src_idx >= 4) || (reg_we && dst_idx >= 4);
    wset = (sp_dec && !sp_inc && m_sp == 8'h00) || (sp_inc && !sp_dec && m_sp == 8'hFF);
    if (mar_src == 1)      m_mar = m_pc;
    else if (mar_src == 2) m_mar = {b, m_mar[7:0]};
    else if (mar_src == 3) m_mar = {m_mar[15:8], b};
    else if (mar_src == 4) m_mar = {8'h01, m_sp};
    if (pc_load_vec) m_pc = 16'hF000;
    else if (pc_load_lo || pc_load_hi) begin
      if (pc_load_lo) m_pc = {m_pc[15:8], b};
      if (pc_load_hi) m_pc = {b, m_pc[7:0]};
    end else if (pc_inc) m_pc = m_pc + 16'd1;
    if (flag_mode == 1)      m_flags = {alu_n, alu_c, alu_z};
    else if (flag_mode == 2) m_flags = {b[7], 1'b0, b == 8'h00};
    if (reg_we && dst_idx < 4) m_regs[dst_idx] = b;
    if (sp_inc && !sp_dec)      m_sp = m_sp + 8'd1;
    else if (sp_dec && !sp_inc) m_sp = m_sp - 8'd1;
    m_err  = eset || (m_err && !err_clr);
    m_wrap = wset || (m_wrap && !err_clr);
    e.bus = b; e.pc = m_pc; e.mar = m_mar; e.sp = m_sp; e.flags = m_flags;
    e.err = m_err; e.wrap = m_wrap; e.reg0 = m_regs[0];
    q.push_back(e);
  endtask

  task automatic idle();
    bus_src = 0; src_idx = 0; dst_idx = 0; reg_we = 0; mem_data_in = 0; alu_result = 0;
    alu_z = 0; alu_c = 0; alu_n = 0; flag_mode = 0; pc_inc = 0; pc_load_lo = 0;
    pc_load_hi = 0; pc_load_vec = 0; mar_src = 0; sp_inc = 0; sp_dec = 0; err_clr = 0;
  endtask

  // Issue the inputs set at this negedge, then move to the next negedge.
  task automatic go();
    model_step();
    @(negedge clk);
  endtask

  // Monitor: bus sampled just before the edge, state just after.
  exp_t       mon_e;
  logic [7:0] mon_bus;
  initial begin
    forever begin
      @(negedge clk); #3;
      mon_bus = bus_out;
      @(posedge clk); #1;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        check("bus",   mon_bus,     mon_e.bus);
        check("pc",    pc_out,      mon_e.pc);
        check("mar",   mem_address, mon_e.mar);
        check("sp",    sp_out,      mon_e.sp);
        check("flags", flags_out,   mon_e.flags);
        check("err",   bus_err,     mon_e.err);
        check("wrap",  sp_wrap,     mon_e.wrap);
        check("reg0",  reg0_out,    mon_e.reg0);
      end
    end
  end

  initial begin
    idle();
    reset = 1'b0;
    model_reset();
    #12;
    check("rst_pc", pc_out, 16'hF000);
    check("rst_sp", sp_out, 8'hFF);
    check("rst_mar", mem_address, 16'h0000);
    check("rst_flags", flags_out, 3'b000);
    check("rst_err", {bus_err, sp_wrap}, 2'b00);
    check("rst_reg0", reg0_out, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    // Load 0x80 into reg2 with load-ZN flags, then read it back
    idle(); bus_src = 1; mem_data_in = 8'h80; reg_we = 1; dst_idx = 2; flag_mode = 2; go();
    check("ld_flags", flags_out, 3'b100);
    idle(); bus_src = 3; src_idx = 2; #1;
    check("rd_reg2", bus_out, 8'h80);
    go();

    // PC carry and byte load overriding increment
    idle(); bus_src = 1; mem_data_in = 8'hFF; pc_load_lo = 1; go();
    idle(); bus_src = 1; mem_data_in = 8'h12; pc_load_hi = 1; go();
    check("pc_12ff", pc_out, 16'h12FF);
    idle(); pc_inc = 1; go();
    check("pc_inc_carry", pc_out, 16'h1300);
    idle(); bus_src = 1; mem_data_in = 8'hAB; pc_load_hi = 1; pc_inc = 1; go();
    check("pc_ld_hi_no_inc", pc_out, 16'hAB00);

    // Stack wrap in both directions and MAR stack address
    idle(); sp_inc = 1; go();
    check("sp_inc_wrap", {sp_out, 7'd0, sp_wrap}, {8'h00, 7'd0, 1'b1});
    idle(); err_clr = 1; go();
    check("wrap_clr", {sp_out, 7'd0, sp_wrap}, {8'h00, 7'd0, 1'b0});
    idle(); mar_src = 4; sp_dec = 1; go();
    check("mar_stack", mem_address, 16'h0100);
    check("sp_dec_wrap", {sp_out, 7'd0, sp_wrap}, {8'hFF, 7'd0, 1'b1});
    idle(); sp_inc = 1; sp_dec = 1; err_clr = 1; go();
    check("sp_hold_clr", {sp_out, 7'd0, sp_wrap}, {8'hFF, 7'd0, 1'b0});

    // Illegal bus source; set beats clear
    idle(); bus_src = 7; mem_data_in = 8'h55; #1;
    check("bus7_zero", bus_out, 8'h00);
    go();
    check("bus7_err", bus_err, 1'b1);
    idle(); bus_src = 7; err_clr = 1; go();
    check("err_set_wins", bus_err, 1'b1);
    idle(); err_clr = 1; go();
    check("err_clr", bus_err, 1'b0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      bus_src     = 3'($urandom_range(0, 7));
      src_idx     = 4'($urandom_range(0, 4));
      dst_idx     = 4'($urandom_range(0, 4));
      reg_we      = 1'($urandom);
      mem_data_in = 8'($urandom);
      alu_result  = 8'($urandom);
      {alu_n, alu_c, alu_z} = 3'($urandom);
      flag_mode   = 2'($urandom);
      pc_inc      = 1'($urandom);
      pc_load_lo  = ($urandom_range(0, 3) == 0);
      pc_load_hi  = ($urandom_range(0, 3) == 0);
      pc_load_vec = ($urandom_range(0, 15) == 0);
      mar_src     = 3'($urandom_range(0, 7));
      sp_inc      = 1'($urandom);
      sp_dec      = 1'($urandom);
      err_clr     = ($urandom_range(0, 7) == 0);
      go();
    end

    // Asynchronous reset between edges with PC = 0x1234
    idle(); bus_src = 1; mem_data_in = 8'h34; pc_load_lo = 1; flag_mode = 1; alu_n = 1; alu_z = 1; go();
    idle(); bus_src = 1; mem_data_in = 8'h12; pc_load_hi = 1; sp_dec = 1; go();
    idle();
    check("pre_rst_pc", pc_out, 16'h1234);
    #2 reset = 1'b0;
    #1;
    check("arst_pc", pc_out, 16'hF000);
    check("arst_sp", sp_out, 8'hFF);
    check("arst_flags", flags_out, 3'b000);
    check("arst_mar", mem_address, 16'h0000);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // NUM_REGS=3 instance: write to nonexistent reg3 is dropped and flagged
    idle(); bus_src = 1; mem_data_in = 8'h5A; reg_we = 1; dst_idx = 3; go();
    check("r3_err", bus_err_3, 1'b1);
    check("r3_reg0", reg0_out_3, 8'h00);
    for (int k = 0; k < 4; k++) begin
      idle(); bus_src = 3; src_idx = 4'(k); #1;
      check("r3_read", bus_out_3, 8'h00);
      go();
    end
    idle(); bus_src = 1; mem_data_in = 8'hC3; reg_we = 1; dst_idx = 2; err_clr = 1; go();
    check("r3_err_clr", bus_err_3, 1'b0);
    idle(); bus_src = 3; src_idx = 2; #1;
    check("r3_read2", bus_out_3, 8'hC3);
    go();

    idle();
    repeat (2) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
